// File: rtl/bcd_to_bin.sv
// rtl/bcd_to_bin.sv - sequential BCD to binary converter using shift-and-subtract-3.
// Define BCD_DIGIT_CHECK_EN to reject inputs containing digits above 9 (err with done).
module bcd_to_bin #(
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bin_out,
  output logic                  err
);

  localparam int W  = 4 * DIGITS;
  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t          state, state_nx;
  logic [2*W-1:0]  work;
  logic [2*W-1:0]  work_step;
  logic [CW-1:0]   cnt;

`ifdef BCD_DIGIT_CHECK_EN
  logic bad;
  logic bad_r;

  always_comb begin
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_in[4*i +: 4] > 4'd9) bad = 1'b1;
    end
  end
`endif

  // Upper half holds the BCD digits; each step moves one bit into the binary half
  // and corrects every digit that borrowed a 10 (value >= 8) by subtracting 3.
  always_comb begin
    work_step = work >> 1;
    for (int i = 0; i < DIGITS; i++) begin
      if (work_step[W + 4*i + 3]) begin
        work_step[W + 4*i +: 4] = work_step[W + 4*i +: 4] - 4'd3;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (start) begin
`ifdef BCD_DIGIT_CHECK_EN
          state_nx = bad ? DONE : SHIFT;
`else
          state_nx = SHIFT;
`endif
        end
      end
      SHIFT: begin
        if (cnt == CW'(W - 1)) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      work    <= '0;
      cnt     <= '0;
      done    <= 1'b0;
      bin_out <= '0;
`ifdef BCD_DIGIT_CHECK_EN
      bad_r   <= 1'b0;
      err     <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            work <= {bcd_in, {W{1'b0}}};
            cnt  <= '0;
`ifdef BCD_DIGIT_CHECK_EN
            bad_r <= bad;
`endif
          end
        end
        SHIFT: begin
          work <= work_step;
          cnt  <= cnt + 1'b1;
        end
        DONE: begin
          done <= 1'b1;
`ifdef BCD_DIGIT_CHECK_EN
          bin_out <= bad_r ? '0 : work[W-1:0];
          err     <= bad_r;
`else
          bin_out <= work[W-1:0];
`endif
        end
        default: ;
      endcase
    end
  end

`ifndef BCD_DIGIT_CHECK_EN
  assign err = 1'b0;
`endif

endmodule
